hazard_ctrl: RTL

//  ID-stage hazard/stall controller feeding the control-path bubble mux. Tracks dest regs of in-flight
//  EX/MEM/WB instrs; drives buble_mux_ctrl (1=pass ctrl, 0=bubble), freezes PC and IF/ID on load-use.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_scoreboard.sv | 84 ++++++++
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the ID-stage hazard controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a. Optional statistics in hazard_ctrl are enabled by macro HAZ_STATS_EN.
package hazard_pkg;

  // Operand source selects carried into ID/EX with the instruction
  localparam logic [1:0] FWD_RF    = 2'b00;  // register file (write-before-read covers WB)
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // ALU result sitting in EX/MEM
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // result sitting in MEM/WB

  // Load-use stall FSM
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Operand forwarding priority: the youngest producer (EX) wins over MEM.
  function automatic logic [1:0] fwd_sel(input logic use_src,
                                         input logic ex_hit,
                                         input logic mem_hit);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src) begin
      if (ex_hit) begin
        sel = FWD_EXMEM;
      end else if (mem_hit) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks {dest, wen, load} of the instructions in EX, MEM and WB.
// Latency: entries advance one stage per clock; match outputs are combinational.
// Backpressure: a bubble (pass=0) shifts an all-zero entry into EX so it never matches.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pass,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_w_enable,
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              ex_match_rs,
  output logic              ex_match_rt,
  output logic              mem_match_rs,
  output logic              mem_match_rt,
  output logic              ex_is_load
);

  logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
  logic              ex_wen_q, ex_wen_d;
  logic              ex_load_q, ex_load_d;
  logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
  logic              mem_wen_q, mem_wen_d;
  logic              mem_load_q, mem_load_d;
  logic [REG_AW-1:0] wb_dest_q, wb_dest_d;
  logic              wb_wen_q, wb_wen_d;
  logic              wb_load_q, wb_load_d;

  // Next entries: EX takes the ID instruction or a zeroed bubble, older stages shift
  always_comb begin
    ex_dest_d  = pass ? id_dest : '0;
    ex_wen_d   = pass & id_w_enable;
    ex_load_d  = pass & id_is_load;
    mem_dest_d = ex_dest_q;
    mem_wen_d  = ex_wen_q;
    mem_load_d = ex_load_q;
    wb_dest_d  = mem_dest_q;
    wb_wen_d   = mem_wen_q;
    wb_load_d  = mem_load_q;
  end

  // Stage registers, cleared to "nothing in flight" on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_dest_q  <= '0;
      ex_wen_q   <= 1'b0;
      ex_load_q  <= 1'b0;
      mem_dest_q <= '0;
      mem_wen_q  <= 1'b0;
      mem_load_q <= 1'b0;
      wb_dest_q  <= '0;
      wb_wen_q   <= 1'b0;
      wb_load_q  <= 1'b0;
    end else begin
      ex_dest_q  <= ex_dest_d;
      ex_wen_q   <= ex_wen_d;
      ex_load_q  <= ex_load_d;
      mem_dest_q <= mem_dest_d;
      mem_wen_q  <= mem_wen_d;
      mem_load_q <= mem_load_d;
      wb_dest_q  <= wb_dest_d;
      wb_wen_q   <= wb_wen_d;
      wb_load_q  <= wb_load_d;
    end
  end

  // Register 0 is hard-wired, so it never counts as a match
  assign ex_match_rs  = ex_wen_q  && (ex_dest_q  == id_rs) && (id_rs != '0);
  assign ex_match_rt  = ex_wen_q  && (ex_dest_q  == id_rt) && (id_rt != '0);
  assign mem_match_rs = mem_wen_q && (mem_dest_q == id_rs) && (id_rs != '0);
  assign mem_match_rt = mem_wen_q && (mem_dest_q == id_rt) && (id_rt != '0);
  assign ex_is_load   = ex_load_q;

  // The regfile writes before it reads, so the WB entry (and the MEM load flag)
  // have no consumer here; they stay to keep the pipeline picture complete.
  logic wb_unused;
  assign wb_unused = ^{wb_dest_q, wb_wen_q, wb_load_q, mem_load_q};

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage load-use stall and forwarding control for the ID/EX bubble mux.
// Latency: all outputs combinational from scoreboard/FSM state and ID inputs (zero cycles).
// Backpressure: on load-use holds PC and IF/ID and bubbles ID/EX for LOAD_USE_STALLS cycles.
// Optional: define HAZ_STATS_EN to add saturating stall_count / fwd_count output ports.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int LOAD_USE_STALLS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_store,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_w_enable,
  input  logic              id_is_load,
  output logic              buble_mux_ctrl,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [1:0]        fwd_ctrl_a,
  output logic [1:0]        fwd_ctrl_b,
  output logic              fwd_dm_ctrl
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       fwd_count
`endif
);

  localparam int CNT_W = $clog2(LOAD_USE_STALLS) + 1;

  logic ex_match_rs, ex_match_rt, mem_match_rs, mem_match_rt, ex_is_load;
  logic load_use;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  hazard_scoreboard #(
    .REG_AW(REG_AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .pass         (buble_mux_ctrl),
    .id_dest      (id_dest),
    .id_w_enable  (id_w_enable),
    .id_is_load   (id_is_load),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_match_rs  (ex_match_rs),
    .ex_match_rt  (ex_match_rt),
    .mem_match_rs (mem_match_rs),
    .mem_match_rt (mem_match_rt),
    .ex_is_load   (ex_is_load)
  );

  // A load in EX feeding an ALU operand; store data is covered by fwd_dm_ctrl instead
  assign load_use = ex_is_load &
                    ((id_uses_rs & ex_match_rs) | (id_uses_rt & ex_match_rt));

  // FSM state and remaining-bubble counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the first bubble is issued from RUN, any extra ones from STALL
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (load_use && (LOAD_USE_STALLS > 1)) begin
          state_d = ST_STALL;
          cnt_d   = CNT_W'(LOAD_USE_STALLS - 1);
        end
      end
      ST_STALL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: pass/bubble and forwarding selects; reset forces a clean pass-through
  always_comb begin
    buble_mux_ctrl = 1'b1;
    fwd_ctrl_a     = FWD_RF;
    fwd_ctrl_b     = FWD_RF;
    fwd_dm_ctrl    = 1'b0;
    if (!rst) begin
      buble_mux_ctrl = (state_q == ST_RUN) && !load_use;
      fwd_ctrl_a     = fwd_sel(id_uses_rs, ex_match_rs, mem_match_rs);
      fwd_ctrl_b     = fwd_sel(id_uses_rt, ex_match_rt, mem_match_rt);
      fwd_dm_ctrl    = id_is_store & ex_is_load & ex_match_rt;
    end
  end

  // PC and IF/ID freeze exactly when ID/EX gets a bubble
  assign pc_write   = buble_mux_ctrl;
  assign ifid_write = buble_mux_ctrl;

`ifdef HAZ_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] fwd_count_q, fwd_count_d;

  // Saturating event counters: bubble cycles, and passing cycles that forward an operand
  always_comb begin
    stall_count_d = stall_count_q;
    fwd_count_d   = fwd_count_q;
    if (!buble_mux_ctrl && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
    if (buble_mux_ctrl && ((fwd_ctrl_a != FWD_RF) || (fwd_ctrl_b != FWD_RF)) &&
        (fwd_count_q != '1)) begin
      fwd_count_d = fwd_count_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
      fwd_count_q   <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign fwd_count   = fwd_count_q;
`endif

endmodule
